rgb_frame_feeder: RTL and testbench

Upstream byte source for `rgb_driver`. Holds a pixel buffer of `NUM_LEDS` 24-bit RGB colours and, on a frame start, streams them as brightness-scaled, colour-ordered bytes to the driver through a valid/request handshake. After the last byte has been shifted out, it holds the line in the latch gap for a fixed number of cycles and then signals frame completion to the host.

---
 rtl/rgb_frame_feeder_pkg.sv | 44 ++++
 rtl/rgb_frame_feeder_if.sv | 10 +
 rtl/rgb_pixel_ram.sv | 33 +++
 rtl/rgb_frame_feeder.sv | 173 +++++++++++++++++
 tb/tb_rgb_frame_feeder.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_frame_feeder_pkg.sv
// rtl/rgb_frame_feeder_pkg.sv - shared types, constants and byte helpers for the RGB frame feeder
package rgb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SEND,
    ST_DRAIN,
    ST_LATCH
  } state_e;

  localparam logic [1:0] BYTE_0 = 2'd0;
  localparam logic [1:0] BYTE_1 = 2'd1;
  localparam logic [1:0] BYTE_2 = 2'd2;

  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

  localparam int LATCH_CYCLES_DEF = 3000;

  // Slot 0/1 swap between R and G for GRB strips; blue is always last.
  function automatic logic [7:0] pick_chan(input logic [23:0] px, input logic [1:0] slot,
                                           input logic grb);
    logic [7:0] c;
    case (slot)
      BYTE_0:  c = grb ? px[G_HI:G_LO] : px[R_HI:R_LO];
      BYTE_1:  c = grb ? px[R_HI:R_LO] : px[G_HI:G_LO];
      default: c = px[B_HI:B_LO];
    endcase
    return c;
  endfunction

  // (c * (br + 1)) >> 8 keeps full scale exact at br = 255.
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
    logic [8:0] k;
    k = {1'b0, br} + 9'd1;
    return 8'(({9'd0, c} * {8'd0, k}) >> 8);
  endfunction

endpackage

// File: rtl/rgb_frame_feeder_if.sv
// rtl/rgb_frame_feeder_if.sv - byte handshake between the frame feeder and the strip driver
interface rgb_frame_feeder_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_req;
  logic       driver_idle;

  modport master (output byte_out, output byte_valid, input byte_req, input driver_idle);
  modport slave  (input byte_out, input byte_valid, output byte_req, output driver_idle);
endinterface

// File: rtl/rgb_pixel_ram.sv
// rtl/rgb_pixel_ram.sv - pixel colour store, one write port and one registered read port
module rgb_pixel_ram #(
  parameter int NUM_LEDS = 16,
  parameter int IDX_W    = 4
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [23:0]      wr_data_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_addr_i,
  output logic [23:0]      rd_data_o
);

  logic [23:0] mem_q [NUM_LEDS];
  logic [23:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i && (32'(wr_addr_i) < NUM_LEDS)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read register doubles as the feeder's pixel register: it only moves on rd_en_i.
  always_ff @(posedge clk) begin
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/rgb_frame_feeder.sv
// rtl/rgb_frame_feeder.sv - streams scaled, colour-ordered pixel bytes to the strip driver per frame
module rgb_frame_feeder
  import rgb_pkg::*;
#(
  parameter int NUM_LEDS     = 16,
  parameter int IDX_W        = 4,
  parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [23:0]      wr_data,
  input  logic [7:0]       brightness,
  input  logic             order_grb,
  input  logic             start,
  output logic             busy,
  output logic             frame_done,
  rgb_frame_feeder_if.master drv
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       slot_q, slot_d;
  logic             wait_q, wait_d;
  logic             seen_low_q, seen_low_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       bright_q, bright_d;
  logic             grb_q, grb_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [7:0]       byte_q, byte_d;
  logic             valid_q, valid_d;

  logic             rd_en;
  logic [23:0]      pixel;

  rgb_pixel_ram #(
    .NUM_LEDS (NUM_LEDS),
    .IDX_W    (IDX_W)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_en_i   (rd_en),
    .rd_addr_i (idx_q),
    .rd_data_o (pixel)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      slot_q     <= BYTE_0;
      wait_q     <= 1'b0;
      seen_low_q <= 1'b0;
      cnt_q      <= '0;
      bright_q   <= '0;
      grb_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      byte_q     <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      slot_q     <= slot_d;
      wait_q     <= wait_d;
      seen_low_q <= seen_low_d;
      cnt_q      <= cnt_d;
      bright_q   <= bright_d;
      grb_q      <= grb_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    slot_d     = slot_q;
    wait_d     = wait_q;
    seen_low_d = seen_low_q;
    cnt_d      = cnt_q;
    bright_d   = bright_q;
    grb_d      = grb_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    byte_d     = byte_q;
    valid_d    = valid_q;
    rd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_FETCH;
          idx_d    = '0;
          bright_d = brightness;
          grb_d    = order_grb;
          busy_d   = 1'b1;
        end
      end

      ST_FETCH: begin
        rd_en   = 1'b1;
        slot_d  = BYTE_0;
        wait_d  = 1'b0;
        state_d = ST_SEND;
      end

      // After each accept: one wait cycle, one load cycle, so the gap is two cycles everywhere.
      ST_SEND: begin
        if (valid_q) begin
          if (drv.byte_req) begin
            valid_d = 1'b0;
            if (slot_q == BYTE_2) begin
              if (idx_q == IDX_W'(NUM_LEDS - 1)) begin
                state_d    = ST_DRAIN;
                seen_low_d = 1'b0;
              end else begin
                idx_d   = idx_q + IDX_W'(1);
                state_d = ST_FETCH;
              end
            end else begin
              slot_d = slot_q + 2'd1;
              wait_d = 1'b1;
            end
          end
        end else if (wait_q) begin
          wait_d = 1'b0;
        end else begin
          byte_d  = scale_chan(pick_chan(pixel, slot_q, grb_q), bright_q);
          valid_d = 1'b1;
        end
      end

      // The driver may still look idle right after the last byte; require a busy phase first.
      ST_DRAIN: begin
        if (seen_low_q && drv.driver_idle) begin
          state_d = ST_LATCH;
          cnt_d   = '0;
        end else if (!drv.driver_idle) begin
          seen_low_d = 1'b1;
        end
      end

      ST_LATCH: begin
        if (cnt_q == 16'(LATCH_CYCLES - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign drv.byte_out   = byte_q;
  assign drv.byte_valid = valid_q;

endmodule

// File: tb/tb_rgb_frame_feeder.sv
// tb/tb_rgb_frame_feeder.sv - directed self-checking bench for rgb_frame_feeder
module tb_rgb_frame_feeder;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [0:0]  wr_addr;
  logic [23:0] wr_data;
  logic [7:0]  brightness;
  logic        order_grb;
  logic        start;
  logic        busy;
  logic        frame_done;
  logic        driver_idle;
  logic        auto_req;
  logic        extra_req;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fd_count = 0;
  int last_acc = 0;
  logic [7:0] log_q[$];
  int         gap_q[$];

  rgb_frame_feeder_if bus ();

  assign bus.byte_req    = auto_req | extra_req;
  assign bus.driver_idle = driver_idle;

  rgb_frame_feeder #(
    .NUM_LEDS     (2),
    .IDX_W        (1),
    .LATCH_CYCLES (10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .brightness (brightness),
    .order_grb  (order_grb),
    .start      (start),
    .busy       (busy),
    .frame_done (frame_done),
    .drv        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (frame_done) fd_count <= fd_count + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  function automatic string tg(input int fid, input string name);
    return $sformatf("f%0d_%s", fid, name);
  endfunction

  // Driver model: request three cycles after each byte_valid rise, log the byte being taken.
  initial begin
    logic prev_v;
    int   dly;
    auto_req = 1'b0;
    prev_v   = 1'b0;
    dly      = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        auto_req = 1'b0;
        prev_v   = 1'b0;
        dly      = 0;
      end else begin
        auto_req = 1'b0;
        if (bus.byte_valid && !prev_v) begin
          gap_q.push_back(cyc - last_acc);
          dly = 2;
        end else if (dly > 0) begin
          dly--;
          if (dly == 0) begin
            auto_req = 1'b1;
            log_q.push_back(bus.byte_out);
            last_acc = cyc + 1;
          end
        end
        prev_v = bus.byte_valid;
      end
    end
  end

  task automatic write_px(input logic [0:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  // mode 0: plain, 1: stray req + mid-frame start, 2: writes during LED0, 3: reset after 3rd byte
  task automatic run_frame(input int fid, input logic [7:0] br, input bit grb,
                           input logic [47:0] exp, input int mode);
    int n;
    int fdc0;
    logic [7:0] got;
    log_q.delete();
    gap_q.delete();
    fdc0 = fd_count;
    @(negedge clk);
    brightness = br;
    order_grb  = grb;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    brightness = ~br;
    order_grb  = ~grb;
    check_eq(tg(fid, "busy_after_e0"), 32'(busy), 32'd1);
    check_eq(tg(fid, "valid_after_e0"), 32'(bus.byte_valid), 32'd0);
    @(negedge clk);
    check_eq(tg(fid, "valid_after_e1"), 32'(bus.byte_valid), 32'd0);
    @(negedge clk);
    check_eq(tg(fid, "valid_after_e2"), 32'(bus.byte_valid), 32'd1);

    if (mode == 1) begin
      n = 0;
      while (!(log_q.size() >= 1 && !bus.byte_valid) && n < 200) begin
        @(negedge clk);
        n++;
      end
      extra_req = 1'b1;
      @(negedge clk);
      extra_req = 1'b0;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
    end

    if (mode == 2) begin
      write_px(1'b1, 24'h010203);
      write_px(1'b0, 24'hFFFFFF);
    end

    if (mode == 3) begin
      n = 0;
      while (!(log_q.size() >= 3 && !bus.byte_valid) && n < 300) begin
        @(negedge clk);
        n++;
      end
      check_eq(tg(fid, "bytes_before_reset"), 32'(log_q.size()), 32'd3);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check_eq(tg(fid, "rst_busy"), 32'(busy), 32'd0);
      check_eq(tg(fid, "rst_valid"), 32'(bus.byte_valid), 32'd0);
      check_eq(tg(fid, "rst_byte"), 32'(bus.byte_out), 32'd0);
      check_eq(tg(fid, "rst_done"), 32'(frame_done), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check_eq(tg(fid, "no_done_after_abort"), 32'(fd_count), 32'(fdc0));
      check_eq(tg(fid, "idle_after_abort"), 32'(busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
        got = (i < log_q.size()) ? log_q[i] : 8'hxx;
        check_eq(tg(fid, $sformatf("byte%0d", i)), 32'(got), 32'(exp[47-8*i -: 8]));
      end
      return;
    end

    n = 0;
    while (!(log_q.size() >= 6 && !bus.byte_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tg(fid, "byte_count"), 32'(log_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      got = (i < log_q.size()) ? log_q[i] : 8'hxx;
      check_eq(tg(fid, $sformatf("byte%0d", i)), 32'(got), 32'(exp[47-8*i -: 8]));
    end
    for (int i = 1; i < 6; i++) begin
      check_eq(tg(fid, $sformatf("gap%0d", i)),
               32'((i < gap_q.size()) ? gap_q[i] : -1), 32'd2);
    end

    repeat (3) @(negedge clk);
    check_eq(tg(fid, "drain_busy"), 32'(busy), 32'd1);
    check_eq(tg(fid, "drain_valid"), 32'(bus.byte_valid), 32'd0);
    check_eq(tg(fid, "drain_done"), 32'(frame_done), 32'd0);

    driver_idle = 1'b0;
    repeat (2) @(negedge clk);
    driver_idle = 1'b1;
    @(posedge clk);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!frame_done && n < 100);
    check_eq(tg(fid, "latch_len"), 32'(n), 32'd10);
    check_eq(tg(fid, "busy_at_done"), 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check_eq(tg(fid, "done_one_cycle"), 32'(frame_done), 32'd0);
    check_eq(tg(fid, "done_pulses"), 32'(fd_count), 32'(fdc0 + 1));
    check_eq(tg(fid, "no_restart"), 32'(busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b1;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    brightness  = 8'hFF;
    order_grb   = 1'b0;
    start       = 1'b0;
    driver_idle = 1'b1;
    extra_req   = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_valid", 32'(bus.byte_valid), 32'd0);
    check_eq("reset_byte", 32'(bus.byte_out), 32'd0);
    check_eq("reset_done", 32'(frame_done), 32'd0);
    reset = 1'b0;

    write_px(1'b0, 24'h112233);
    write_px(1'b1, 24'hA0B0C0);
    run_frame(1, 8'd255, 1'b1, 48'h22_11_33_B0_A0_C0, 0);

    write_px(1'b0, 24'hFF8001);
    run_frame(2, 8'd127, 1'b0, 48'h7F_40_00_50_58_60, 1);

    run_frame(3, 8'd255, 1'b0, 48'hFF_80_01_00_00_00, 3);
    run_frame(4, 8'd255, 1'b0, 48'hFF_80_01_01_02_03, 2);
    run_frame(5, 8'd255, 1'b0, 48'hFF_FF_FF_01_02_03, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
